// File: rtl/prisc_pkg.sv
// Shared pRISC definitions used by the fetch unit and its buffer.
//   INSTR_W  : instruction / address width
//   PC_RESET : value the PC register takes on reset (one step before 0)
//   PC_STEP  : byte distance between consecutive instructions
//   fetch_state_t : fetch request state (IDLE / WAIT / DRAIN)
package prisc_pkg;

    localparam int              INSTR_W  = 32;
    localparam logic [31:0]     PC_RESET = 32'hFFFF_FFFC;
    localparam logic [31:0]     PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no request outstanding
        WAIT  = 2'd1,   // request outstanding, response will be kept
        DRAIN = 2'd2    // request outstanding, response will be thrown away
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus (req/ack handshake).
//   imem_req   : read request, held until acknowledged
//   imem_addr  : fetch address, stable while imem_req is high
//   imem_ack   : response valid this cycle (meaningful only while imem_req)
//   imem_rdata : instruction word, valid with imem_ack
// master = fetch unit, slave = instruction memory.
interface instr_fetch_unit_if;
    import prisc_pkg::*;

    logic               imem_req;
    logic [INSTR_W-1:0] imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/instr_fetch_unit_fetch_buf.sv
// fetch_buf: synchronous FIFO of {pc, instr} pairs feeding decode.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empties the FIFO this cycle (wins over push/pop)
//   push       : write {push_pc, push_instr}; accepted when not full or when
//                popping in the same cycle
//   pop        : drop the head entry (ignored when empty)
//   head_pc    : head address (0 when empty)
//   head_instr : head instruction (0 when empty)
//   count      : number of valid entries, full, empty : status flags
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_buf
    import prisc_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  logic [INSTR_W-1:0] push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic               pop,
    output logic [INSTR_W-1:0] head_pc,
    output logic [INSTR_W-1:0] head_instr,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [INSTR_W-1:0] pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    // Empty buffer presents zeros so decode never sees stale words.
    assign head_pc    = empty ? '0 : pc_mem[rd_ptr];
    assign head_instr = empty ? '0 : instr_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: pRISC instruction fetch.
// Reads the current PC, drives the PC register's next value every cycle,
// issues instruction-memory reads over a req/ack bus and buffers fetched
// words toward decode. Taken branches redirect fetch and flush the buffer,
// including a response still in flight.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   pc_in             : current PC (address of the last issued fetch)
//   next_pc           : combinational next PC value
//   imem              : instruction-memory bus (master side)
//   instr_valid/instr/instr_pc/instr_ready : decode handshake (buffer head)
//   br_taken/br_target: single-cycle redirect request
//   fetch_fault       : sticky misaligned-redirect flag, present only when
//                       FETCH_ALIGN_CHECK_EN is defined
// Configuration macro: FETCH_ALIGN_CHECK_EN
//   defined   : misaligned redirects are refused and raise fetch_fault,
//               which blocks all further issue until reset
//   undefined : br_target[1:0] is forced to zero
module instr_fetch_unit
    import prisc_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INSTR_W-1:0]  pc_in,
    output logic [INSTR_W-1:0]  next_pc,
    instr_fetch_unit_if.master  imem,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [INSTR_W-1:0]  instr_pc,
    input  logic                instr_ready,
    input  logic                br_taken,
    input  logic [INSTR_W-1:0]  br_target
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic                fetch_fault
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_t       state;
    logic [CNT_W-1:0]   buf_count;
    logic               buf_full;
    logic               buf_empty;
    logic               ack;
    logic               redirect;
    logic               block_issue;
    logic               push_raw;
    logic               pop_raw;
    logic [CNT_W:0]     count_after;
    logic               space;
    logic               issue;
    logic [INSTR_W-1:0] target;

`ifdef FETCH_ALIGN_CHECK_EN
    logic align_bad;
    assign align_bad   = br_taken && (br_target[1:0] != 2'b00);
    assign target      = br_target;
    assign redirect    = br_taken && !align_bad;
    // The faulting cycle itself already stops issue.
    assign block_issue = fetch_fault || align_bad;
`else
    assign target      = br_target & ~32'h3;
    assign redirect    = br_taken;
    assign block_issue = 1'b0;
`endif

    assign ack      = imem.imem_req && imem.imem_ack;
    assign push_raw = (state == WAIT) && ack && (!buf_full || pop_raw);
    assign pop_raw  = !buf_empty && instr_ready;

    // Occupancy after this cycle's push and pop decides whether another
    // request may be launched; at most one request is ever outstanding.
    assign count_after = {1'b0, buf_count} + (CNT_W+1)'(push_raw) - (CNT_W+1)'(pop_raw);
    assign space       = count_after < (CNT_W+1)'(BUF_DEPTH);
    assign issue       = !redirect && !block_issue && space &&
                         ((state == IDLE) || push_raw);

    always_comb begin
        next_pc = pc_in;
        if (!rst) begin
            // PC holds the last issued address, so aim one step before target.
            if (redirect)   next_pc = target - PC_STEP;
            else if (issue) next_pc = pc_in + PC_STEP;
        end
    end

    fetch_buf #(
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect),
        .push       (push_raw && !redirect),
        .push_pc    (imem.imem_addr),
        .push_instr (imem.imem_rdata),
        .pop        (pop_raw && !redirect),
        .head_pc    (instr_pc),
        .head_instr (instr),
        .count      (buf_count),
        .full       (buf_full),
        .empty      (buf_empty)
    );

    assign instr_valid = !buf_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            imem.imem_req  <= 1'b0;
            imem.imem_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        imem.imem_req  <= 1'b1;
                        imem.imem_addr <= pc_in + PC_STEP;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        if (ack) begin
                            imem.imem_req <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            // Bus must see the old request through to its ack.
                            state <= DRAIN;
                        end
                    end else if (ack) begin
                        if (issue) begin
                            imem.imem_addr <= pc_in + PC_STEP;
                        end else begin
                            imem.imem_req <= 1'b0;
                            state         <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (ack) begin
                        imem.imem_req <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    imem.imem_req <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)            fetch_fault <= 1'b0;
        else if (align_bad) fetch_fault <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: PC register and instruction-memory models,
// a cycle table for the streaming case and directed sequences for
// back-pressure, redirects, reset and misaligned targets. Delivered words
// are checked against a queue of expected addresses.
module tb_instr_fetch_unit;
    import prisc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_reg;
    logic [31:0] next_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'd0;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    instr_fetch_unit_if imem_bus();

    instr_fetch_unit #(.BUF_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_reg),
        .next_pc     (next_pc),
        .imem        (imem_bus.master),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .br_taken    (br_taken),
        .br_target   (br_target)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_fault (fetch_fault)
`endif
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rst) pc_reg <= PC_RESET;
        else     pc_reg <= next_pc;
    end

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic auto_ack = 1'b1;
    logic man_ack  = 1'b0;
    int   lat      = 1;
    int   wcnt     = 0;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] ipc;
        logic [31:0] npc;
    } vec_t;
    vec_t tbl[7];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic respond();
        if (auto_ack) begin
            if (imem_bus.imem_req) begin
                if (wcnt >= lat - 1) begin
                    imem_bus.imem_ack = 1'b1;
                    wcnt = 0;
                end else begin
                    imem_bus.imem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                imem_bus.imem_ack = 1'b0;
                wcnt = 0;
            end
        end else begin
            imem_bus.imem_ack = man_ack;
        end
        imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);
    endtask

    task automatic monitor();
        logic [31:0] e;
        if (!rst && instr_valid && instr_ready && !br_taken) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_delivery: got pc %h expected none", instr_pc);
            end else begin
                e = exp_q.pop_front();
                chk32("deliv_pc", instr_pc, e);
                chk32("deliv_instr", instr, mem_word(e));
            end
        end
    endtask

    // Drive this cycle's inputs, let the memory answer, check deliveries.
    task automatic set_in(input logic r, input logic rdy, input logic br, input logic [31:0] tgt);
        rst = r;
        instr_ready = rdy;
        br_taken = br;
        br_target = tgt;
        respond();
        #1;
        monitor();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        man_ack = 1'b0;
        repeat (2) begin
            set_in(1'b1, 1'b0, 1'b0, 32'd0);
            adv();
        end
        wcnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           rst   rdy   req   addr   vld   ipc    npc
        tbl[0] = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b0, 32'd0,  32'hFFFF_FFFC};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 32'd0,  1'b0, 32'd0,  32'd0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0,  32'd4};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 32'd4,  1'b1, 32'd0,  32'd8};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 32'd8,  1'b1, 32'd4,  32'd12};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 32'd12, 1'b1, 32'd8,  32'd16};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 32'd16, 1'b1, 32'd12, 32'd20};

        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'd0;
        adv();

        // Streaming: single-cycle ack, decode always ready.
        auto_ack = 1'b1;
        lat = 1;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(4 * i));
        for (int i = 0; i < 7; i++) begin
            set_in(tbl[i].rst, tbl[i].rdy, 1'b0, 32'd0);
            chk1("t_req", imem_bus.imem_req, tbl[i].req);
            chk32("t_addr", imem_bus.imem_addr, tbl[i].addr);
            chk1("t_valid", instr_valid, tbl[i].vld);
            chk32("t_instr_pc", instr_pc, tbl[i].ipc);
            chk32("t_next_pc", next_pc, tbl[i].npc);
            if (tbl[i].rst) chk32("t_reset_instr", instr, 32'd0);
            adv();
        end
        chk32("s1_all_delivered", 32'(exp_q.size()), 32'd0);

        // Back-pressure with 2-cycle ack latency.
        lat = 2;
        do_reset();
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd4);
        exp_q.push_back(32'd8);
        set_in(1'b0, 1'b0, 1'b0, 32'd0); adv();
        set_in(1'b0, 1'b0, 1'b0, 32'd0); adv();
        set_in(1'b0, 1'b0, 1'b0, 32'd0);
        chk32("s2_npc_reissue", next_pc, 32'd4);
        adv();
        set_in(1'b0, 1'b0, 1'b0, 32'd0);
        chk1("s2_first_valid", instr_valid, 1'b1);
        adv();
        set_in(1'b0, 1'b0, 1'b0, 32'd0); adv();
        repeat (3) begin
            set_in(1'b0, 1'b0, 1'b0, 32'd0);
            chk1("s2_req_dropped", imem_bus.imem_req, 1'b0);
            chk32("s2_npc_hold", next_pc, 32'd4);
            chk32("s2_head_pc", instr_pc, 32'd0);
            adv();
        end
        set_in(1'b0, 1'b1, 1'b0, 32'd0);
        chk32("s2_resume_npc", next_pc, 32'd8);
        adv();
        set_in(1'b0, 1'b1, 1'b0, 32'd0);
        chk1("s2_resume_req", imem_bus.imem_req, 1'b1);
        chk32("s2_resume_addr", imem_bus.imem_addr, 32'd8);
        adv();
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
            set_in(1'b0, 1'b1, 1'b0, 32'd0);
            adv();
        end
        chk32("s2_all_delivered", 32'(exp_q.size()), 32'd0);

        // Redirect while the request at 0x8 is still waiting.
        auto_ack = 1'b0;
        do_reset();
        exp_q.push_back(32'd0);
        exp_q.push_back(32'h100);
        set_in(1'b0, 1'b1, 1'b0, 32'd0); adv();
        man_ack = 1'b1; set_in(1'b0, 1'b1, 1'b0, 32'd0); adv();
        man_ack = 1'b1; set_in(1'b0, 1'b1, 1'b0, 32'd0); adv();
        man_ack = 1'b0; set_in(1'b0, 1'b0, 1'b0, 32'd0);
        chk32("s3_wait_addr", imem_bus.imem_addr, 32'h8);
        chk32("s3_head_pc", instr_pc, 32'h4);
        adv();
        set_in(1'b0, 1'b0, 1'b0, 32'd0); adv();
        set_in(1'b0, 1'b0, 1'b1, 32'h100);
        chk32("s3_redirect_npc", next_pc, 32'hFC);
        adv();
        set_in(1'b0, 1'b0, 1'b0, 32'd0);
        chk1("s3_flushed", instr_valid, 1'b0);
        chk1("s3_drain_req", imem_bus.imem_req, 1'b1);
        chk32("s3_drain_addr", imem_bus.imem_addr, 32'h8);
        chk32("s3_drain_npc", next_pc, 32'hFC);
        adv();
        man_ack = 1'b1; set_in(1'b0, 1'b0, 1'b0, 32'd0); adv();
        man_ack = 1'b0; set_in(1'b0, 1'b0, 1'b0, 32'd0);
        chk1("s3_idle_req", imem_bus.imem_req, 1'b0);
        chk1("s3_discarded", instr_valid, 1'b0);
        chk32("s3_issue_npc", next_pc, 32'h100);
        adv();
        man_ack = 1'b1; set_in(1'b0, 1'b0, 1'b0, 32'd0);
        chk1("s3_new_req", imem_bus.imem_req, 1'b1);
        chk32("s3_new_addr", imem_bus.imem_addr, 32'h100);
        adv();
        man_ack = 1'b0; set_in(1'b0, 1'b1, 1'b0, 32'd0);
        chk32("s3_target_head", instr_pc, 32'h100);
        adv();
        set_in(1'b0, 1'b0, 1'b0, 32'd0); adv();
        chk32("s3_all_delivered", 32'(exp_q.size()), 32'd0);

        // Redirect in the same cycle as the ack.
        do_reset();
        exp_q.push_back(32'h200);
        set_in(1'b0, 1'b0, 1'b0, 32'd0); adv();
        man_ack = 1'b1; set_in(1'b0, 1'b0, 1'b0, 32'd0); adv();
        man_ack = 1'b0; set_in(1'b0, 1'b0, 1'b0, 32'd0);
        chk1("s4_valid_before", instr_valid, 1'b1);
        adv();
        man_ack = 1'b1; set_in(1'b0, 1'b0, 1'b1, 32'h200);
        chk32("s4_redirect_npc", next_pc, 32'h1FC);
        adv();
        man_ack = 1'b0; set_in(1'b0, 1'b0, 1'b0, 32'd0);
        chk1("s4_req_dropped", imem_bus.imem_req, 1'b0);
        chk1("s4_acked_word_void", instr_valid, 1'b0);
        chk32("s4_issue_npc", next_pc, 32'h200);
        adv();
        man_ack = 1'b1; set_in(1'b0, 1'b0, 1'b0, 32'd0);
        chk1("s4_new_req", imem_bus.imem_req, 1'b1);
        chk32("s4_new_addr", imem_bus.imem_addr, 32'h200);
        adv();
        man_ack = 1'b0; set_in(1'b0, 1'b1, 1'b0, 32'd0); adv();
        set_in(1'b0, 1'b0, 1'b0, 32'd0); adv();
        chk32("s4_all_delivered", 32'(exp_q.size()), 32'd0);

        // Reset while a request waits.
        do_reset();
        set_in(1'b0, 1'b0, 1'b0, 32'd0); adv();
        man_ack = 1'b1; set_in(1'b0, 1'b0, 1'b0, 32'd0); adv();
        man_ack = 1'b0; set_in(1'b1, 1'b0, 1'b0, 32'd0);
        chk32("s5_npc_in_reset", next_pc, 32'h4);
        adv();
        set_in(1'b0, 1'b0, 1'b0, 32'd0);
        chk1("s5_req_abandoned", imem_bus.imem_req, 1'b0);
        chk1("s5_valid_cleared", instr_valid, 1'b0);
        chk32("s5_instr_cleared", instr, 32'd0);
        chk32("s5_release_npc", next_pc, 32'd0);
        adv();
        set_in(1'b0, 1'b0, 1'b0, 32'd0);
        chk1("s5_first_req", imem_bus.imem_req, 1'b1);
        chk32("s5_first_addr", imem_bus.imem_addr, 32'd0);
        adv();

        // Misaligned redirect target.
        do_reset();
        set_in(1'b0, 1'b0, 1'b0, 32'd0); adv();
        set_in(1'b0, 1'b0, 1'b1, 32'h302);
`ifdef FETCH_ALIGN_CHECK_EN
        chk32("s6_no_redirect_npc", next_pc, 32'd0);
        adv();
        man_ack = 1'b1; set_in(1'b0, 1'b0, 1'b0, 32'd0);
        chk1("s6_fault_set", fetch_fault, 1'b1);
        chk1("s6_req_kept", imem_bus.imem_req, 1'b1);
        chk32("s6_addr_kept", imem_bus.imem_addr, 32'd0);
        adv();
        man_ack = 1'b0;
        repeat (3) begin
            set_in(1'b0, 1'b0, 1'b0, 32'd0);
            chk1("s6_no_issue", imem_bus.imem_req, 1'b0);
            chk1("s6_fault_sticky", fetch_fault, 1'b1);
            chk32("s6_kept_entry", instr_pc, 32'd0);
            adv();
        end
`else
        chk32("s6_forced_npc", next_pc, 32'h2FC);
        adv();
        man_ack = 1'b1; set_in(1'b0, 1'b0, 1'b0, 32'd0); adv();
        man_ack = 1'b0; set_in(1'b0, 1'b0, 1'b0, 32'd0);
        chk1("s6_idle_req", imem_bus.imem_req, 1'b0);
        chk32("s6_issue_npc", next_pc, 32'h300);
        adv();
        set_in(1'b0, 1'b0, 1'b0, 32'd0);
        chk1("s6_new_req", imem_bus.imem_req, 1'b1);
        chk32("s6_new_addr", imem_bus.imem_addr, 32'h300);
        adv();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
